// File: rtl/md_unit_seq.sv
// rtl/md_unit_seq.sv - iterative radix-2 multiply/divide unit with HI/LO, MADD/MSUB and flush cancel
module md_unit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic               neg_res_q, neg_rem_q, divz_q;
    logic [WIDTH-1:0]   b_q, p_hi, p_lo, hi_q, lo_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               done_q, dbz_q;

    logic               accept, op_div, op_div_q, src2_zero, signed_op, s1, s2;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, shifted;
    logic [WIDTH-1:0]   trial;
    logic               fits;
    logic [2*WIDTH-1:0] prod, acc_res;
    logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;

    assign accept    = (state_q == IDLE) && start && !cancel;
    assign op_div    = (op[2:1] == 2'b01);
    assign op_div_q  = (op_q[2:1] == 2'b01);
    assign src2_zero = (src2 == '0);
    assign signed_op = ~op[0];
    assign s1        = signed_op & src1[WIDTH-1];
    assign s2        = signed_op & src2[WIDTH-1];
    assign a_abs     = s1 ? -src1 : src1;
    assign b_abs     = s2 ? -src2 : src2;

    // Multiply: p_lo holds the remaining multiplier bits, p_hi the running upper half.
    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Divide: p_hi is the partial remainder, p_lo shifts dividend out and quotient in.
    assign shifted   = {p_hi, p_lo[WIDTH-1]};
    assign fits      = shifted >= {1'b0, b_q};
    assign trial     = shifted[WIDTH-1:0] - b_q;

    assign prod      = neg_res_q ? -{p_hi, p_lo} : {p_hi, p_lo};
    assign acc_res   = op_q[1] ? (acc_q - prod) : (acc_q + prod);
    assign quot      = neg_res_q ? -p_lo : p_lo;
    assign rem       = neg_rem_q ? -p_hi : p_hi;

    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (divz_q) begin
            fix_hi = acc_q[WIDTH-1:0];
            fix_lo = '1;
        end else if (op_div_q) begin
            fix_hi = rem;
            fix_lo = quot;
        end else if (op_q[2]) begin
            fix_hi = acc_res[2*WIDTH-1:WIDTH];
            fix_lo = acc_res[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (op_div && src2_zero) ? FIX : CALC;
            CALC: begin
                if (cancel)
                    state_d = IDLE;
                else if (cnt_q == CW'(WIDTH-1))
                    state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            b_q       <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= op;
                        neg_res_q <= s1 ^ s2;
                        neg_rem_q <= s1;
                        divz_q    <= op_div && src2_zero;
                        b_q       <= b_abs;
                        p_hi      <= '0;
                        p_lo      <= a_abs;
                        cnt_q     <= '0;
                        // Divides reuse the accumulator to carry the raw dividend for divide-by-zero.
                        acc_q     <= op_div ? {{WIDTH{1'b0}}, src1} : {hi_q, lo_q};
                    end else begin
                        if (wr_hi) hi_q <= wdata;
                        if (wr_lo) lo_q <= wdata;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (op_div_q) begin
                        p_hi <= fits ? trial : shifted[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], fits};
                    end else begin
                        p_hi <= mul_sum[WIDTH:1];
                        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                        dbz_q  <= divz_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/md_unit_seq.md
Name: md_unit_seq

Overview:
- Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the single-cycle ALU. Replaces the combinational array multiplier and divider with radix-2 iterative datapaths (one bit per cycle).
- Adds multiply-accumulate and multiply-subtract, divide-by-zero detection, flush cancel, and direct HI/LO writes.
- The pipeline stalls on busy and consumes hi/lo after done.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; product is 2*WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when state is IDLE.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- src1  in  WIDTH  multiplicand / dividend.
- src2  in  WIDTH  multiplier / divisor.
- cancel  in  1  pipeline flush; aborts the operation in flight.
- wr_hi  in  1  write wdata to HI (MTHI).
- wr_lo  in  1  write wdata to LO (MTLO).
- wdata  in  WIDTH  direct HI/LO write data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; hi/lo are updated in the same cycle.
- div_by_zero  out  1  valid only while done is high; 1 when a DIV/DIVU had src2 equal to 0.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (async, resetn=0): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; iteration counter cleared. Reset mid-operation discards the operation.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1, cancel=0: latch op, sign flags and absolute-value operands. Signed ops take absolute values; unsigned ops pass operands through. Latch {hi,lo} as the accumulator. Go to CALC with counter=0.
- Start exception: DIV/DIVU with src2=0 goes directly to FIX.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Stay for exactly WIDTH cycles, then go to FIX.
- FIX: apply sign correction. Signed product is negated if sign(src1)^sign(src2). Signed quotient is negated if signs differ, so it truncates toward zero. Signed remainder takes the sign of the dividend.
- FIX accumulate: MADD/MADDU: {hi,lo} = acc + product. MSUB/MSUBU: {hi,lo} = acc - product. Both modulo 2^(2*WIDTH).
- FIX divide-by-zero: lo = all ones; hi = src2-independent dividend (src1 as latched, not absolute-valued); div_by_zero=1.
- FIX exit: on the edge leaving FIX, write hi/lo, assert done for 1 cycle, return to IDLE.
- Latency: start sampled in cycle 0; busy high in cycles 1..WIDTH+1; done and new hi/lo visible in cycle WIDTH+2. Divide-by-zero: busy in cycle 1 only; done in cycle 2.
- Signed overflow (most-negative / -1): lo = 2^(WIDTH-1), hi = 0; no special flag.
- Back-to-back: a start in the cycle where done=1 is accepted (state is IDLE). Accumulate ops in that cycle see the freshly written hi/lo.
- start while busy: ignored; the caller must hold the request.
- cancel: in CALC or FIX, return to IDLE on the next edge; hi/lo unchanged; no done. cancel with start in IDLE: start ignored. cancel in IDLE: no effect.
- Direct writes: wr_hi/wr_lo take effect on the edge only when state is IDLE and start is not being accepted; otherwise they are ignored. wr_hi and wr_lo may be asserted together.
- done and div_by_zero are registered and deasserted in every cycle except the completion cycle.

Test Plan:
- WIDTH=32, MULT src1=0xFFFFFFFD, src2=5 -> cycle 34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high cycles 1..33.
- DIVU 100/7 then DIV 0xFFFFFFF9/2 back-to-back (second start in done cycle) -> first: lo=14, hi=2; second done 34 cycles after its start: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU src1=0x1234, src2=0 -> cycle 2: done=1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x1234.
- wr_hi=0, wr_lo with wdata=0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0. Then MSUB 1*2 -> hi=0, lo=0xFFFFFFFE.
- MULT started, cancel asserted in cycle 10 -> busy=0 from cycle 11; no done ever; hi/lo keep prior values. New start in cycle 11 completes normally.
- Async reset mid-CALC (resetn low at cycle 5) -> busy, done and hi/lo all 0 immediately. wr_hi during busy -> ignored.
